// File: rtl/nn_pkg.sv
// Shared definitions for the neuron feeder: Q8.8 constants, buffer write-select codes
// and the feeder FSM state type.
package nn_pkg;

   localparam int          Q_FRAC = 8;
   localparam logic [15:0] Q_ONE  = 16'h0100;

   localparam logic [1:0] SEL_X = 2'd0;
   localparam logic [1:0] SEL_W = 2'd1;
   localparam logic [1:0] SEL_B = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2,
      EMIT   = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/neuron_feeder_if.sv
// Bus bundle between the feeder, its host/writer, the neuron and the next layer.
// Handshakes: no ready anywhere; out_valid, n_start and layer_done are one-cycle strobes whose
// data is stable while the strobe is high, and the consumer must take every out_valid.
interface neuron_feeder_if #(
   parameter int N = 4,
   parameter int M = 4,
   parameter int W = 16
);
   import nn_pkg::*;

   localparam int AW = (M * N > 1) ? $clog2(M * N) : 1;
   localparam int JW = (M > 1) ? $clog2(M) : 1;

   logic          wr_en;
   logic [1:0]    wr_sel;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          go;
   logic          busy;
   logic          n_start;
   logic [W-1:0]  n_x;
   logic [W-1:0]  n_w;
   logic [W-1:0]  n_b;
   logic [W-1:0]  n_act;
   logic          n_done;
   logic          out_valid;
   logic [JW-1:0] out_idx;
   logic [W-1:0]  out_data;
   logic          layer_done;
   logic          err;
   feeder_state_t state;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, go, n_act, n_done,
      input  busy, n_start, n_x, n_w, n_b, out_valid, out_idx, out_data, layer_done, err, state
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, go, n_act, n_done,
      output busy, n_start, n_x, n_w, n_b, out_valid, out_idx, out_data, layer_done, err, state
   );

endinterface

// File: rtl/neuron_feeder_operand_bank.sv
// Operand storage for one layer pass: input vector x, row-major weights w and biases b.
// Single write port, combinational reads addressed by the feeder's (j, i) counters.
module operand_bank
   import nn_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int M  = 4,
   parameter  int W  = 16,
   localparam int IW = (N > 1) ? $clog2(N) : 1,
   localparam int JW = (M > 1) ? $clog2(M) : 1,
   localparam int AW = (M * N > 1) ? $clog2(M * N) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [1:0]    sel,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  data,
   input  logic [IW-1:0] rd_i,
   input  logic [JW-1:0] rd_j,
   output logic [W-1:0]  x_rd,
   output logic [W-1:0]  w_rd,
   output logic [W-1:0]  b_rd
);

   logic [W-1:0]  x_mem [N];
   logic [W-1:0]  w_mem [M*N];
   logic [W-1:0]  b_mem [M];
   logic [AW-1:0] w_idx;

   assign w_idx = AW'(rd_j) * AW'(N) + AW'(rd_i);
   assign x_rd  = x_mem[rd_i];
   assign w_rd  = w_mem[w_idx];
   assign b_rd  = b_mem[rd_j];

   // Contents survive reset; addresses past the end of the selected array are dropped.
   always_ff @(posedge clk) begin
      if (we) begin
         case (sel)
            SEL_X:   if (int'(addr) < N)     x_mem[addr[IW-1:0]] <= data;
            SEL_W:   if (int'(addr) < M * N) w_mem[addr]         <= data;
            SEL_B:   if (int'(addr) < M)     b_mem[addr[JW-1:0]] <= data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/neuron_feeder.sv
// Layer sequencer: runs one serial neuron M times over a stored vector/weight matrix,
// streaming operand pairs and re-emitting each activation as a strobed result.
module neuron_feeder
   import nn_pkg::*;
#(
   parameter int N       = 4,
   parameter int M       = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst,
   neuron_feeder_if.slave bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int JW = (M > 1) ? $clog2(M) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   feeder_state_t state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [TW-1:0] t_q, t_d;
   logic [W-1:0]  act_q, act_d;
   logic          busy_q, busy_d, n_start_q, n_start_d, out_valid_q, out_valid_d;
   logic          layer_done_q, layer_done_d, err_q, err_d;
   logic [W-1:0]  n_x_q, n_x_d, n_w_q, n_w_d, n_b_q, n_b_d, out_data_q, out_data_d;
   logic [JW-1:0] out_idx_q, out_idx_d;
   logic [W-1:0]  x_rd, w_rd, b_rd;

   operand_bank #(.N(N), .M(M), .W(W)) u_bank (
      .clk  (clk),
      .we   (bus.wr_en && (state_q == IDLE)),
      .sel  (bus.wr_sel),
      .addr (bus.wr_addr),
      .data (bus.wr_data),
      .rd_i (i_q),
      .rd_j (j_q),
      .x_rd (x_rd),
      .w_rd (w_rd),
      .b_rd (b_rd)
   );

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      t_d          = t_q;
      act_d        = act_q;
      busy_d       = busy_q;
      n_start_d    = 1'b0;
      n_x_d        = n_x_q;
      n_w_d        = n_w_q;
      n_b_d        = n_b_q;
      out_valid_d  = 1'b0;
      out_idx_d    = out_idx_q;
      out_data_d   = out_data_q;
      layer_done_d = 1'b0;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (bus.go) begin
               state_d = STREAM;
               i_d     = '0;
               j_d     = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         STREAM: begin
            n_start_d = (i_q == '0);
            n_x_d     = x_rd;
            n_w_d     = w_rd;
            n_b_d     = b_rd;
            if (i_q == IW'(N - 1)) begin
               state_d = WAIT;
               t_d     = '0;
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         WAIT: begin
            // act_q buffers the result so out_data only moves together with out_valid.
            if (bus.n_done) begin
               act_d   = bus.n_act;
               state_d = EMIT;
            end else if (t_q == TW'(TIMEOUT - 1)) begin
               err_d        = 1'b1;
               layer_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         EMIT: begin
            out_valid_d = 1'b1;
            out_idx_d   = j_q;
            out_data_d  = act_q;
            if (j_q == JW'(M - 1)) begin
               layer_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end else begin
               j_d     = j_q + JW'(1);
               i_d     = '0;
               state_d = STREAM;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         i_q          <= '0;
         j_q          <= '0;
         t_q          <= '0;
         act_q        <= '0;
         busy_q       <= 1'b0;
         n_start_q    <= 1'b0;
         n_x_q        <= '0;
         n_w_q        <= '0;
         n_b_q        <= '0;
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         out_data_q   <= '0;
         layer_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         j_q          <= j_d;
         t_q          <= t_d;
         act_q        <= act_d;
         busy_q       <= busy_d;
         n_start_q    <= n_start_d;
         n_x_q        <= n_x_d;
         n_w_q        <= n_w_d;
         n_b_q        <= n_b_d;
         out_valid_q  <= out_valid_d;
         out_idx_q    <= out_idx_d;
         out_data_q   <= out_data_d;
         layer_done_q <= layer_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.n_start    = n_start_q;
   assign bus.n_x        = n_x_q;
   assign bus.n_w        = n_w_q;
   assign bus.n_b        = n_b_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_idx    = out_idx_q;
   assign bus.out_data   = out_data_q;
   assign bus.layer_done = layer_done_q;
   assign bus.err        = err_q;
   assign bus.state      = state_q;

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Upstream sequencer for the serial `neuron` MAC stage (Q8.8, one x/w pair per cycle, `start` marks the first pair).
- Holds one input vector, an M×N weight matrix and M biases. Runs the single neuron M times, once per output.
- Streams operands to the neuron, captures each `activation` on the neuron's `done`, and presents results as a valid-strobed stream to the next layer.

Parameters:
- N, 4, inputs per neuron (vector length; must equal the neuron's N).
- M, 4, outputs per layer (neuron invocations per pass).
- W, 16, data width (signed Q8.8).
- TIMEOUT, 64, max cycles to wait for `n_done` after the last pair before aborting.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  buffer write strobe; honoured only in IDLE.
- wr_sel  in  2  write target: 0 = x[addr], 1 = w[addr] (row-major, addr = j*N+i), 2 = b[addr], 3 = ignored.
- wr_addr  in  clog2(M*N)  write address; out-of-range writes are dropped.
- wr_data  in  W  signed write data.
- go  in  1  start a layer pass; accepted only in IDLE.
- busy  out  1  high from the cycle after `go` is accepted until the cycle `layer_done` pulses.
- n_start  out  1  to neuron `start`.
- n_x  out  W  to neuron `x`.
- n_w  out  W  to neuron `w`.
- n_b  out  W  to neuron `b`.
- n_act  in  W  from neuron `activation`.
- n_done  in  1  from neuron `done`.
- out_valid  out  1  one-cycle result strobe.
- out_idx  out  clog2(M)  output index j.
- out_data  out  W  captured activation for output j.
- layer_done  out  1  one-cycle pulse at the end of a pass (normal or aborted).
- err  out  1  sticky timeout flag; cleared by `rst` or by the next accepted `go`.

Behaviour:
- Reset: state = IDLE. All outputs are 0: `busy`, `n_start`, `n_x`, `n_w`, `n_b`, `out_valid`, `out_idx`, `out_data`, `layer_done`, `err`. Buffer contents are not cleared. Reset mid-pass aborts immediately with no `layer_done`.
- FSM states: IDLE, STREAM, WAIT, EMIT. All outputs are registered.
- IDLE:
  - `go` = 1 → STREAM with j = 0, i = 0, `err` cleared.
  - `wr_en` is applied the same cycle. `wr_en` together with `go` applies the write first, so the pass sees the new data.
- STREAM:
  - One pair per cycle for i = 0..N-1: `n_x` = x[i], `n_w` = w[j*N+i], `n_b` = b[j].
  - `n_start` = 1 only on the i = 0 cycle.
  - After i = N-1 → WAIT. The timeout counter is cleared on entry.
  - `n_x` and `n_w` hold their last value outside STREAM; `n_b` holds b[j] through WAIT.
- First-pair latency: `go` sampled at edge t → `n_start` = 1 with pair 0 visible after edge t+1.
- WAIT:
  - `n_done` = 1 → capture `n_act` into `out_data`, go to EMIT.
  - `n_done` asserted during STREAM is ignored.
  - Counter reaches TIMEOUT with no `n_done` → set `err`, pulse `layer_done`, go to IDLE. No further outputs are produced.
- EMIT:
  - `out_valid` = 1 for exactly one cycle, with `out_idx` = j and `out_data` stable.
  - If j < M-1: j++, go to STREAM (the next `n_start` follows on the next cycle).
  - Otherwise: `layer_done` = 1 the same cycle, go to IDLE.
- `out_data` and `out_idx` hold their values until the next EMIT.
- Per-output cost: N + L_neuron + 1 cycles. There is no back-pressure; the consumer must accept every `out_valid`.
- `go` while `busy` is ignored. `wr_en` while `busy` is ignored, so buffers are frozen for the whole pass.
- No arithmetic is performed on data; widths pass through unchanged.
- Index counters wrap only via explicit FSM control; no counter may overflow silently.

Decomposition:
- Shared package `nn_pkg`:
  - Q8.8 constants: `Q_FRAC` = 8, `Q_ONE` = 16'h0100.
  - Write-select encodings: `SEL_X`, `SEL_W`, `SEL_B`.
  - FSM state typedef `feeder_state_t`.
- One sub-module, `operand_bank`: three register arrays (x, w, b) with a write port and combinational read by index. The FSM and counters stay in `neuron_feeder`.

Test Plan:
1. Basic pass, against a real `neuron` (N=4), M=1.
   - Stimulus: load x = [0x0100, 0x0200, 0x0300, 0x0400], w row 0 = [0x0080, 0x0180, 0x0280, 0x0380], b[0] = 0x0500; pulse `go`.
   - Required: `n_start` high exactly one cycle, pairs in order, `out_valid` once with `out_idx` = 0 and `out_data` = 0x1E00 (30.0), then `layer_done`. `err` = 0.
2. Multi-output pass, M=4.
   - Stimulus: same x; w row j = all 0x0100; b[j] = j*0x0100.
   - Required: outputs idx 0..3 = 0x0A00, 0x0B00, 0x0C00, 0x0D00 in order; `busy` high throughout; one `layer_done` after the idx 3 strobe.
3. Frozen buffers.
   - Stimulus: `wr_en` to x[0] = 0x7FFF and a second `go`, both during scenario 1's WAIT.
   - Required: result is still 0x1E00, no restart. After IDLE, the write takes effect on the next pass.
4. Timeout.
   - Stimulus: stub neuron that never asserts `done`, TIMEOUT = 64.
   - Required: `layer_done` and `err` = 1 exactly 64 cycles after the last pair; no `out_valid`. The next `go` clears `err`.
5. Reset mid-STREAM.
   - Stimulus: assert `rst` on the i = 2 cycle.
   - Required: the following cycle has all outputs 0, state IDLE, no `layer_done`. A subsequent `go` reproduces the scenario 1 result 0x1E00 (buffers retained).
6. Edge writes.
   - Stimulus: `wr_sel` = 3 and an out-of-range `wr_addr`.
   - Required: no buffer change. A pass then gives the previous results unchanged.
